program_fetch: RTL and testbench

PROGRAM_FETCH -- requirements
Module: program_fetch

---
 rtl/program_fetch_if.sv | 11 +
 rtl/program_fetch.sv | 107 ++++++++++
 tb/tb_program_fetch.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_fetch_if.sv
// Program-load handshake bundle: one 16-bit instruction word per accepted beat,
// with loadLast marking the final beat of a program.
interface program_fetch_if;
  logic        loadValid;
  logic        loadReady;
  logic [15:0] loadData;
  logic        loadLast;

  modport master (output loadValid, output loadData, output loadLast, input loadReady);
  modport slave  (input loadValid, input loadData, input loadLast, output loadReady);
endinterface

// File: rtl/program_fetch.sv
// Program store and fetch sequencer: loads up to 256 instruction words, then
// feeds them to the decoder by PC while tracking run state and RUN cycle count.
module program_fetch #(
  parameter logic [15:0] HALT_WORD = 16'hE000
) (
  input  logic                  clk,
  input  logic                  rst,
  program_fetch_if.slave        lb,
  input  logic                  start,
  input  logic                  clear,
  input  logic [7:0]            instructionAddress,
  input  logic                  haltCondition,
  output logic [15:0]           instruction,
  output logic                  halt,
  output logic                  running,
  output logic [8:0]            programLength,
  output logic [15:0]           cycleCount
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    READY  = 3'd2,
    RUN    = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  wrPtr_q, wrPtr_d;
  logic [8:0]  len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] mem_q [256];
  logic        accept;

  assign lb.loadReady = (state_q == IDLE) || (state_q == LOAD);
  // clear takes priority over a simultaneous beat, so that beat is never stored
  assign accept = lb.loadValid && lb.loadReady && !clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wrPtr_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wrPtr_q <= wrPtr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wrPtr_d = wrPtr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = IDLE;
      wrPtr_d = '0;
      len_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, LOAD: begin
          if (accept) begin
            wrPtr_d = wrPtr_q + 9'd1;
            // the 256th beat closes the program even without loadLast
            if (lb.loadLast || (wrPtr_q == 9'd255)) begin
              state_d = READY;
              len_d   = wrPtr_q + 9'd1;
            end else begin
              state_d = LOAD;
            end
          end
        end
        READY: begin
          if (start) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        RUN: begin
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          if (haltCondition) state_d = HALTED;
        end
        HALTED: begin
          if (start) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // storage is deliberately not reset; rst only blocks writes
  always_ff @(posedge clk) begin
    if (rst && accept) mem_q[wrPtr_q[7:0]] <= lb.loadData;
  end

  assign instruction   = ((state_q == RUN) && ({1'b0, instructionAddress} < len_q))
                         ? mem_q[instructionAddress] : HALT_WORD;
  assign halt          = (state_q != RUN);
  assign running       = (state_q == RUN);
  assign programLength = len_q;
  assign cycleCount    = cnt_q;

endmodule

// File: tb/tb_program_fetch.sv
// Bench for program_fetch: directed scenarios plus randomized load/run sessions
// compared against a program-array model.
module tb_program_fetch;
  localparam logic [15:0] HW = 16'hE000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, clear, haltCondition;
  logic [7:0]  instructionAddress;
  logic [15:0] instruction;
  logic        halt, running;
  logic [8:0]  programLength;
  logic [15:0] cycleCount;

  int errors = 0;
  int checks = 0;

  logic [15:0] prog [256];
  int          prog_len;

  always #5 clk = ~clk;

  program_fetch_if lif ();

  program_fetch #(.HALT_WORD(HW)) dut (
    .clk                (clk),
    .rst                (rst),
    .lb                 (lif),
    .start              (start),
    .clear              (clear),
    .instructionAddress (instructionAddress),
    .haltCondition      (haltCondition),
    .instruction        (instruction),
    .halt               (halt),
    .running            (running),
    .programLength      (programLength),
    .cycleCount         (cycleCount)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] d, input logic last);
    lif.loadValid = 1'b1;
    lif.loadData  = d;
    lif.loadLast  = last;
    step();
    lif.loadValid = 1'b0;
    lif.loadLast  = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++; if (lif.loadReady !== 1'b1) begin errors++; $display("FAIL reset_loadReady got=%b want=1", lif.loadReady); end
    checks++; if (halt !== 1'b1)          begin errors++; $display("FAIL reset_halt got=%b want=1", halt); end
    checks++; if (running !== 1'b0)       begin errors++; $display("FAIL reset_running got=%b want=0", running); end
    checks++; if (instruction !== HW)     begin errors++; $display("FAIL reset_instr got=%h want=%h", instruction, HW); end
    checks++; if (programLength !== 9'd0) begin errors++; $display("FAIL reset_len got=%0d want=0", programLength); end
    checks++; if (cycleCount !== 16'd0)   begin errors++; $display("FAIL reset_cnt got=%0d want=0", cycleCount); end
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_load_small();
    logic [15:0] words [3];
    words[0] = 16'h0105; words[1] = 16'h4211; words[2] = 16'hE000;
    for (int i = 0; i < 3; i++) begin
      checks++; if (lif.loadReady !== 1'b1) begin errors++; $display("FAIL small_ready beat=%0d got=%b want=1", i, lif.loadReady); end
      beat(words[i], i == 2);
    end
    checks++; if (programLength !== 9'd3) begin errors++; $display("FAIL small_len got=%0d want=3", programLength); end
    checks++; if (lif.loadReady !== 1'b0) begin errors++; $display("FAIL small_ready_after got=%b want=0", lif.loadReady); end
    checks++; if (halt !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL small_ready_state halt=%b running=%b want 1/0", halt, running); end
  endtask

  task automatic test_run();
    logic [15:0] expv [3];
    expv[0] = 16'h0105; expv[1] = 16'h4211; expv[2] = 16'hE000;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (running !== 1'b1 || halt !== 1'b0) begin errors++; $display("FAIL run_enter running=%b halt=%b want 1/0", running, halt); end
    checks++; if (cycleCount !== 16'd0) begin errors++; $display("FAIL run_cnt0 got=%0d want=0", cycleCount); end
    for (int i = 0; i < 3; i++) begin
      instructionAddress = 8'(i);
      haltCondition = (i == 2);
      #1;
      checks++; if (instruction !== expv[i]) begin errors++; $display("FAIL run_instr addr=%0d got=%h want=%h", i, instruction, expv[i]); end
      step();
    end
    haltCondition = 1'b0;
    checks++; if (running !== 1'b0 || halt !== 1'b1) begin errors++; $display("FAIL run_halted running=%b halt=%b want 0/1", running, halt); end
    checks++; if (cycleCount !== 16'd3) begin errors++; $display("FAIL run_cnt got=%0d want=3", cycleCount); end
    instructionAddress = 8'd0;
    #1;
    checks++; if (instruction !== HW) begin errors++; $display("FAIL halted_instr got=%h want=%h", instruction, HW); end
  endtask

  task automatic test_resume_out_of_range();
    haltCondition = 1'b1;
    step();
    haltCondition = 1'b0;
    checks++; if (cycleCount !== 16'd3) begin errors++; $display("FAIL halt_ignored_cnt got=%0d want=3", cycleCount); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL resume_running got=%b want=1", running); end
    checks++; if (cycleCount !== 16'd3) begin errors++; $display("FAIL resume_cnt got=%0d want=3", cycleCount); end
    instructionAddress = 8'd5;
    #1;
    checks++; if (instruction !== HW) begin errors++; $display("FAIL oor_instr5 got=%h want=%h", instruction, HW); end
    instructionAddress = 8'd3;
    #1;
    checks++; if (instruction !== HW) begin errors++; $display("FAIL oor_instr3 got=%h want=%h", instruction, HW); end
    haltCondition = 1'b1;
    step();
    haltCondition = 1'b0;
    checks++; if (cycleCount !== 16'd4 || running !== 1'b0) begin errors++; $display("FAIL resume_halt cnt=%0d running=%b want 4/0", cycleCount, running); end
  endtask

  task automatic test_clear_priority();
    clear = 1'b1;
    start = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    checks++; if (lif.loadReady !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL clear_state ready=%b running=%b want 1/0", lif.loadReady, running); end
    checks++; if (programLength !== 9'd0) begin errors++; $display("FAIL clear_len got=%0d want=0", programLength); end
    checks++; if (cycleCount !== 16'd0) begin errors++; $display("FAIL clear_cnt got=%0d want=0", cycleCount); end
    // clear against a live beat: pointer restarts at 0 for the next program
    beat(16'h1111, 1'b0);
    clear = 1'b1;
    lif.loadValid = 1'b1; lif.loadData = 16'h2222; lif.loadLast = 1'b1;
    step();
    clear = 1'b0;
    lif.loadValid = 1'b0; lif.loadLast = 1'b0;
    checks++; if (lif.loadReady !== 1'b1 || programLength !== 9'd0) begin errors++; $display("FAIL clear_beat ready=%b len=%0d want 1/0", lif.loadReady, programLength); end
    beat(16'h3333, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    instructionAddress = 8'd0;
    #1;
    checks++; if (instruction !== 16'h3333) begin errors++; $display("FAIL clear_reload got=%h want=3333", instruction); end
    do_clear();
  endtask

  task automatic test_full_load();
    for (int i = 0; i < 256; i++) begin
      prog[i] = 16'($urandom);
      checks++; if (lif.loadReady !== 1'b1) begin errors++; $display("FAIL full_ready beat=%0d got=%b want=1", i, lif.loadReady); end
      beat(prog[i], 1'b0);
    end
    checks++; if (programLength !== 9'd256) begin errors++; $display("FAIL full_len got=%0d want=256", programLength); end
    checks++; if (lif.loadReady !== 1'b0) begin errors++; $display("FAIL full_ready_after got=%b want=0", lif.loadReady); end
    beat(~prog[0], 1'b1);
    checks++; if (programLength !== 9'd256 || lif.loadReady !== 1'b0) begin errors++; $display("FAIL full_257 len=%0d ready=%b want 256/0", programLength, lif.loadReady); end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      instructionAddress = 8'(i);
      haltCondition = (i == 255);
      #1;
      checks++; if (instruction !== prog[i]) begin errors++; $display("FAIL full_read addr=%0d got=%h want=%h", i, instruction, prog[i]); end
      step();
    end
    haltCondition = 1'b0;
    checks++; if (cycleCount !== 16'd256 || running !== 1'b0) begin errors++; $display("FAIL full_cnt cnt=%0d running=%b want 256/0", cycleCount, running); end
    do_clear();
  endtask

  task automatic test_reset_midload();
    beat(16'hAAAA, 1'b0);
    beat(16'hBBBB, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (lif.loadReady !== 1'b1 || programLength !== 9'd0) begin errors++; $display("FAIL rst_mid ready=%b len=%0d want 1/0", lif.loadReady, programLength); end
    lif.loadValid = 1'b1; lif.loadData = 16'hDEAD; lif.loadLast = 1'b1;
    step(); step();
    lif.loadValid = 1'b0; lif.loadLast = 1'b0;
    checks++; if (programLength !== 9'd0 || lif.loadReady !== 1'b1) begin errors++; $display("FAIL rst_hold len=%0d ready=%b want 0/1", programLength, lif.loadReady); end
    rst = 1'b1;
    step();
    beat(16'h5A5A, 1'b1);
    checks++; if (programLength !== 9'd1) begin errors++; $display("FAIL rst_reload_len got=%0d want=1", programLength); end
    start = 1'b1;
    step();
    start = 1'b0;
    instructionAddress = 8'd0;
    #1;
    checks++; if (instruction !== 16'h5A5A) begin errors++; $display("FAIL rst_reload_w0 got=%h want=5a5a", instruction); end
    instructionAddress = 8'd1;
    #1;
    checks++; if (instruction !== HW) begin errors++; $display("FAIL rst_reload_w1 got=%h want=%h", instruction, HW); end
    do_clear();
  endtask

  task automatic test_random();
    bit          m_run;
    int          m_cnt;
    logic [15:0] want;
    for (int s = 0; s < 6; s++) begin
      prog_len = $urandom_range(1, 24);
      for (int i = 0; i < prog_len; i++) begin
        prog[i] = 16'($urandom);
        beat(prog[i], i == prog_len - 1);
      end
      checks++; if (programLength !== 9'(prog_len)) begin errors++; $display("FAIL rnd_len sess=%0d got=%0d want=%0d", s, programLength, prog_len); end
      start = 1'b1;
      step();
      start = 1'b0;
      m_run = 1'b1;
      m_cnt = 0;
      for (int c = 0; c < 60; c++) begin
        instructionAddress = 8'($urandom_range(0, 31));
        haltCondition = ($urandom_range(0, 7) == 0);
        start = ($urandom_range(0, 3) == 0);
        #1;
        want = (m_run && instructionAddress < prog_len) ? prog[instructionAddress] : HW;
        checks++; if (instruction !== want) begin errors++; $display("FAIL rnd_instr sess=%0d cyc=%0d got=%h want=%h", s, c, instruction, want); end
        checks++; if (running !== m_run || cycleCount !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_state sess=%0d cyc=%0d run=%b cnt=%0d want %b/%0d", s, c, running, cycleCount, m_run, m_cnt); end
        if (m_run) begin
          m_cnt++;
          if (haltCondition) m_run = 1'b0;
        end else if (start) begin
          m_run = 1'b1;
        end
        step();
      end
      start = 1'b0;
      haltCondition = 1'b0;
      do_clear();
    end
  endtask

  initial begin
    lif.loadValid = 1'b0;
    lif.loadData  = '0;
    lif.loadLast  = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    haltCondition = 1'b0;
    instructionAddress = '0;
    rst = 1'b1;
    #3;
    test_reset();
    test_load_small();
    test_run();
    test_resume_out_of_range();
    test_clear_priority();
    test_full_load();
    test_reset_midload();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
